// File: rtl/thumb_fetch_ctrl.sv
// thumb_fetch_ctrl: halfword fetch sequencer with a prefetch FIFO feeding inst_decode.
// Optional macro FETCH_THUMB32_EN enables 32-bit Thumb prefix pairing; undefined, every halfword issues alone.
module thumb_fetch_ctrl #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              dec_ready,
    output logic              ir_valid,
    output logic [15:0]       ir_q0,
    output logic [15:0]       ir_q1,
    output logic              isThumb,
    output logic [ADDR_W-1:0] ir_pc
);
    localparam int unsigned       PTR_W   = $clog2(BUF_DEPTH);
    localparam int unsigned       CNT_W   = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t            r_state;
    logic [15:0]       r_buf [BUF_DEPTH];
    logic [PTR_W-1:0]  r_rd;
    logic [PTR_W-1:0]  r_wr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_ir_pc;
    logic [ADDR_W-1:0] r_addr;
    logic              r_req;

    logic [15:0]       w_head;
    logic              w_prefix;
    logic              w_valid;
    logic              w_push;
    logic [1:0]        w_pop_n;
    logic [CNT_W-1:0]  w_count_nx;
    logic [ADDR_W-1:0] w_fetch_pc_inc;
    logic [ADDR_W-1:0] w_tgt;

    assign w_head = r_buf[r_rd];

`ifdef FETCH_THUMB32_EN
    logic [15:0] w_second;
    assign w_second = r_buf[r_rd + PTR_W'(1)];
    // 11101/11110/11111: top three bits set and the next two not both zero
    assign w_prefix = (w_head[15:13] == 3'b111) && (w_head[12:11] != 2'b00);
    assign w_valid  = w_prefix ? (r_count >= CNT_W'(2)) : (r_count != '0);
    assign ir_q1    = (w_valid && w_prefix) ? w_second : '0;
`else
    assign w_prefix = 1'b0;
    assign w_valid  = (r_count != '0);
    assign ir_q1    = '0;
`endif

    assign ir_valid  = w_valid;
    assign ir_q0     = w_valid ? w_head : '0;
    assign isThumb   = !(w_valid && w_prefix);
    assign ir_pc     = r_ir_pc;
    assign imem_req  = r_req;
    assign imem_addr = r_addr;

    assign w_push         = (r_state == REQ) && imem_ack;
    assign w_pop_n        = !(w_valid && dec_ready) ? 2'd0 : (w_prefix ? 2'd2 : 2'd1);
    assign w_count_nx     = r_count + CNT_W'(w_push) - CNT_W'(w_pop_n);
    assign w_fetch_pc_inc = r_fetch_pc + ADDR_W'(2);
    assign w_tgt          = branch_target & PC_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC & PC_MASK;
            r_fetch_pc <= RESET_PC & PC_MASK;
            r_ir_pc    <= RESET_PC & PC_MASK;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
        end else if (branch_valid) begin
            r_fetch_pc <= w_tgt;
            r_ir_pc    <= w_tgt;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_req      <= 1'b1;
            // An unacknowledged request must still complete at its old address
            if (r_state != IDLE && !imem_ack) begin
                r_state <= DRAIN;
            end else begin
                r_state <= REQ;
                r_addr  <= w_tgt;
            end
        end else begin
            if (w_push) begin
                r_buf[r_wr] <= imem_rdata;
                r_wr        <= r_wr + PTR_W'(1);
            end
            r_rd    <= r_rd + PTR_W'(w_pop_n);
            r_count <= w_count_nx;
            r_ir_pc <= r_ir_pc + ADDR_W'({w_pop_n, 1'b0});
            case (r_state)
                IDLE: begin
                    if (w_count_nx < CNT_W'(BUF_DEPTH)) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_addr  <= r_fetch_pc;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        r_fetch_pc <= w_fetch_pc_inc;
                        r_addr     <= w_fetch_pc_inc;
                        if (w_count_nx >= CNT_W'(BUF_DEPTH)) begin
                            r_state <= IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        r_state <= REQ;
                        r_addr  <= r_fetch_pc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_thumb_fetch_ctrl.sv
// Testbench for thumb_fetch_ctrl: directed scenarios then random traffic, checked against an
// instruction-stream model (occupancy, expected PC/halfwords, expected fetch address).
module tb_thumb_fetch_ctrl;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = '0;
    logic        dec_ready = 1'b0;
    logic        ir_valid;
    logic [15:0] ir_q0;
    logic [15:0] ir_q1;
    logic        isThumb;
    logic [31:0] ir_pc;

    thumb_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .branch_valid(branch_valid),
        .branch_target(branch_target), .dec_ready(dec_ready), .ir_valid(ir_valid),
        .ir_q0(ir_q0), .ir_q1(ir_q1), .isThumb(isThumb), .ir_pc(ir_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [15:0] mem [256];
    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        return mem[a[8:1]];
    endfunction
    task automatic mem_wr(input logic [31:0] a, input logic [15:0] v);
        mem[a[8:1]] = v;
    endtask
    task automatic fill_safe();
        for (int unsigned i = 0; i < 256; i++) mem[i] = 16'h2000 | 16'(i);
    endtask

    function automatic logic is_pf(input logic [15:0] h);
`ifdef FETCH_THUMB32_EN
        return (h[15:11] == 5'b11101) || (h[15:11] == 5'b11110) || (h[15:11] == 5'b11111);
`else
        return 1'b0;
`endif
    endfunction

    // Memory responder: ack after lat (+ extra delay at one address) cycles of a held request
    int unsigned lat = 0;
    int unsigned delay_cycles = 0;
    logic [31:0] delay_addr = 32'h1;
    int unsigned wcnt = 0;
    always @(posedge clk) begin
        int unsigned eff;
        #1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        if (imem_req) begin
            eff = lat + ((imem_addr == delay_addr) ? delay_cycles : 0);
            if (wcnt >= eff) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_rd(imem_addr);
                wcnt       = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Reference model: halfwords held = fetched-and-kept minus issued
    logic [31:0] m_fetch, m_pc, m_drain_addr;
    logic        m_drain;
    int          m_occ;
    int          n_issued = 0;
    always @(negedge clk) begin
        logic [15:0] h0, h1;
        logic        pf, ev;
        logic [31:0] tgt;
        if (rst) begin
            m_fetch = 32'h0; m_pc = 32'h0; m_drain = 1'b0; m_drain_addr = 32'h0; m_occ = 0;
        end else begin
            h0 = mem_rd(m_pc);
            h1 = mem_rd(m_pc + 32'd2);
            pf = is_pf(h0);
            ev = pf ? (m_occ >= 2) : (m_occ >= 1);
            chk("ir_valid", ir_valid, ev);
            if (ev) begin
                chk("ir_q0", ir_q0, h0);
                chk("ir_q1", ir_q1, pf ? h1 : 16'h0);
                chk("isThumb", isThumb, !pf);
                chk("ir_pc", ir_pc, m_pc);
            end else begin
                chk("idle_q0", ir_q0, 16'h0);
                chk("idle_q1", ir_q1, 16'h0);
                chk("idle_isThumb", isThumb, 1'b1);
            end
            if (imem_req) chk("imem_addr", imem_addr, m_drain ? m_drain_addr : m_fetch);
            if (ev && dec_ready) n_issued++;
            if (branch_valid) begin
                if (imem_req && !imem_ack) begin
                    if (!m_drain) begin m_drain = 1'b1; m_drain_addr = m_fetch; end
                end else begin
                    m_drain = 1'b0;
                end
                tgt = branch_target & ~32'h1;
                m_fetch = tgt; m_pc = tgt; m_occ = 0;
            end else begin
                if (imem_req && imem_ack) begin
                    if (m_drain) m_drain = 1'b0;
                    else begin m_fetch = m_fetch + 32'd2; m_occ++; end
                end
                if (ev && dec_ready) begin
                    m_occ = m_occ - (pf ? 2 : 1);
                    m_pc  = m_pc + (pf ? 32'd4 : 32'd2);
                end
                chk("occupancy_le_depth", (m_occ <= DEPTH), 1'b1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1; branch_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        int acks, waitc, nval, found;
        logic seen6, seenhi;
        logic [31:0] naddr;
        logic [15:0] r;

        // Test 1: reset state and first 16-bit issue
        fill_safe(); mem_wr(32'h0, 16'h1C08);
        lat = 0; dec_ready = 1'b1;
        do_reset();
        @(negedge clk);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", ir_valid, 1'b0);
        chk("rst_q0", ir_q0, 16'h0);
        chk("rst_q1", ir_q1, 16'h0);
        chk("rst_isThumb", isThumb, 1'b1);
        chk("rst_pc", ir_pc, 32'h0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ir_valid) begin found = 1; break; end
        end
        chk("t1_valid_seen", found, 1);
        chk("t1_q0", ir_q0, 16'h1C08);
        chk("t1_isThumb", isThumb, 1'b1);
        chk("t1_pc", ir_pc, 32'h0);

        // Test 2: F000/F800 pair
        step(); fill_safe(); mem_wr(32'h0, 16'hF000); mem_wr(32'h2, 16'hF800);
        do_reset();
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ir_valid) begin found = 1; break; end
        end
        chk("t2_valid_seen", found, 1);
        chk("t2_q0", ir_q0, 16'hF000);
`ifdef FETCH_THUMB32_EN
        chk("t2_q1", ir_q1, 16'hF800);
        chk("t2_isThumb", isThumb, 1'b0);
`else
        chk("t2_q1", ir_q1, 16'h0);
        chk("t2_isThumb", isThumb, 1'b1);
`endif
        chk("t2_pc", ir_pc, 32'h0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ir_valid) begin found = 1; break; end
        end
        chk("t2_next_seen", found, 1);
`ifdef FETCH_THUMB32_EN
        chk("t2_next_pc", ir_pc, 32'h4);
`else
        chk("t2_next_pc", ir_pc, 32'h2);
`endif

        // Test 3: decoder stalled fills the FIFO then fetch stops
        step(); fill_safe(); dec_ready = 1'b0;
        do_reset();
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req && imem_ack) acks++;
        end
        chk("t3_acks", acks, 4);
        chk("t3_req_idle", imem_req, 1'b0);
        step(); dec_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req) begin found = 1; break; end
        end
        chk("t3_resume_seen", found, 1);
        chk("t3_resume_addr", imem_addr, 32'h8);

        // Test 4: branch while a slow request is outstanding
        step(); fill_safe(); lat = 3;
        do_reset();
        found = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h6 && !imem_ack) begin found = 1; break; end
        end
        chk("t4_req6_seen", found, 1);
        step(); branch_valid = 1'b1; branch_target = 32'h101;
        step(); branch_valid = 1'b0;
        found = 0; seen6 = 1'b0; naddr = 32'h0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ir_valid && ir_pc == 32'h6) seen6 = 1'b1;
            if (imem_req && imem_addr != 32'h6) begin found = 1; naddr = imem_addr; break; end
        end
        chk("t4_next_req_seen", found, 1);
        chk("t4_next_addr", naddr, 32'h100);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ir_valid && ir_pc == 32'h6) seen6 = 1'b1;
        end
        chk("t4_no_pc6", seen6, 1'b0);

        // Test 5: prefix with late second halfword
        step(); fill_safe(); lat = 0;
        mem_wr(32'h0, 16'hF000); mem_wr(32'h2, 16'hF801);
        delay_addr = 32'h2; delay_cycles = 5;
        do_reset();
        waitc = 0; nval = 0; found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h2) begin
                if (imem_ack) begin found = 1; break; end
                waitc++;
                if (ir_valid) nval++;
            end
        end
        chk("t5_ack_seen", found, 1);
        chk("t5_wait_cycles", waitc, 5);
        @(negedge clk);
        chk("t5_valid", ir_valid, 1'b1);
`ifdef FETCH_THUMB32_EN
        chk("t5_valid_during_wait", nval, 0);
        chk("t5_q0", ir_q0, 16'hF000);
        chk("t5_q1", ir_q1, 16'hF801);
        chk("t5_isThumb", isThumb, 1'b0);
        chk("t5_pc", ir_pc, 32'h0);
`else
        chk("t5_valid_during_wait", nval, 1);
        chk("t5_q0", ir_q0, 16'hF801);
        chk("t5_isThumb", isThumb, 1'b1);
        chk("t5_pc", ir_pc, 32'h2);
`endif
        delay_addr = 32'h1; delay_cycles = 0;

        // Test 6: reset during an active request
        found = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (imem_req) begin found = 1; break; end
        end
        chk("t6_req_seen", found, 1);
        rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("t6_req", imem_req, 1'b0);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_valid", ir_valid, 1'b0);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req) begin found = 1; break; end
        end
        chk("t6_restart_seen", found, 1);
        chk("t6_restart_addr", imem_addr, 32'h0);

        // PC wrap at 2^32
        step(); branch_valid = 1'b1; branch_target = 32'hFFFF_FFFD;
        step(); branch_valid = 1'b0;
        found = 0; seenhi = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ir_valid && ir_pc == 32'hFFFF_FFFC) seenhi = 1'b1;
            if (ir_valid && ir_pc == 32'h0 && seenhi) begin found = 1; break; end
        end
        chk("wrap_pc_zero", found, 1);

        // Random traffic
        step();
        for (int unsigned i = 0; i < 256; i++) begin
            r = 16'($urandom);
            if ($urandom_range(3) == 0) r[15:11] = 5'b11101 + 5'($urandom_range(2));
            mem[i] = r;
        end
        do_reset();
        n_issued = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) lat = $urandom_range(3);
            dec_ready    = ($urandom_range(9) < 7);
            branch_valid = ($urandom_range(39) == 0);
            branch_target = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15))
                                                     : $urandom_range(511);
            step();
        end
        branch_valid = 1'b0;
        step();
        chk("rand_progress", (n_issued > 200), 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
